// File: rtl/packet_framer_tx.sv
// rtl/packet_framer_tx.sv - frames SYNC/LEN/OPCODE/payload/CRC-8 replies onto the uart_core TX byte handshake
module packet_framer_tx #(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC        = 8'hAA
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     pkt_valid,
  output logic                     pkt_ready,
  input  logic [7:0]               pkt_opcode,
  input  logic [7:0]               pkt_len,
  input  logic [8*MAX_PAYLOAD-1:0] pkt_payload,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err_len
);

  typedef enum logic [2:0] {IDLE, S_SYNC, S_LEN, S_OP, S_PAY, S_CRC} state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t                   state_q, state_d;
  logic [7:0]               op_q, op_d;
  logic [7:0]               len_q, len_d;
  logic [8*MAX_PAYLOAD-1:0] pay_q, pay_d;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               crc_q, crc_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [7:0]               cur_byte;

  // CRC-8 poly 0x07, MSB-first, one byte per call
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] x;
    x = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    end
    return x;
  endfunction

  assign pkt_ready = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err_len   = err_q;
  assign tx_data   = cur_byte;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    pay_d    = pay_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cur_byte = 8'h00;
    tx_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pkt_valid && pkt_ready) begin
          if (pkt_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            op_d    = pkt_opcode;
            len_d   = pkt_len;
            pay_d   = pkt_payload;
            idx_d   = 8'h00;
            crc_d   = 8'h00;
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        cur_byte = SYNC;
        if (tx_ready) state_d = S_LEN;
      end
      S_LEN: begin
        tx_valid = 1'b1;
        cur_byte = len_q + 8'd1;
        if (tx_ready) begin
          crc_d   = crc8_upd(crc_q, cur_byte);
          state_d = S_OP;
        end
      end
      S_OP: begin
        tx_valid = 1'b1;
        cur_byte = op_q;
        if (tx_ready) begin
          crc_d   = crc8_upd(crc_q, cur_byte);
          state_d = (len_q == 8'h00) ? S_CRC : S_PAY;
        end
      end
      S_PAY: begin
        tx_valid = 1'b1;
        cur_byte = 8'(pay_q >> {idx_q, 3'b000});
        if (tx_ready) begin
          crc_d = crc8_upd(crc_q, cur_byte);
          if (idx_q == len_q - 8'd1) state_d = S_CRC;
          else                       idx_d   = idx_q + 8'd1;
        end
      end
      S_CRC: begin
        tx_valid = 1'b1;
        cur_byte = crc_q;
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      len_q   <= 8'h00;
      pay_q   <= '0;
      idx_q   <= 8'h00;
      crc_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_packet_framer_tx.sv
// tb/tb_packet_framer_tx.sv - scoreboard bench for packet_framer_tx
module tb_packet_framer_tx;

  localparam int MAXP = 16;

  logic             CLK = 1'b0;
  logic             rst_n = 1'b0;
  logic             pkt_valid = 1'b0;
  logic             pkt_ready;
  logic [7:0]       pkt_opcode = 8'h00;
  logic [7:0]       pkt_len = 8'h00;
  logic [8*MAXP-1:0] pkt_payload = '0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err_len;

  packet_framer_tx #(.MAX_PAYLOAD(MAXP), .SYNC(8'hAA)) dut (
    .CLK(CLK), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_opcode(pkt_opcode), .pkt_len(pkt_len), .pkt_payload(pkt_payload),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err_len(err_len)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int cyc = 0, hs_cyc = 0, done_gap = 0, acc_cnt = 0;
  int busy_cnt = 0, done_cnt = 0, err_cnt = 0, txv_cnt = 0, nready_cnt = 0;
  bit prev_stall = 0, rand_ready = 0;
  logic [7:0] prev_data = 8'h00;

  // Reference CRC written bit-serially from the polynomial definition.
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] op, input logic [7:0] len, input logic [8*MAXP-1:0] pay);
    logic [7:0] c, b;
    c = 8'h00;
    exp_q.push_back(8'hAA);
    b = len + 8'd1;
    exp_q.push_back(b);
    c = crc_model(c, b);
    exp_q.push_back(op);
    c = crc_model(c, op);
    for (int i = 0; i < int'(len); i++) begin
      b = pay[8*i +: 8];
      exp_q.push_back(b);
      c = crc_model(c, b);
    end
    exp_q.push_back(c);
  endtask

  // Negedge monitor: scoreboard pop on every handshake, stall stability, event counters.
  task automatic tick();
    logic [7:0] e;
    @(negedge CLK);
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
      return;
    end
    if (busy) busy_cnt++;
    if (tx_valid) txv_cnt++;
    if (err_len) err_cnt++;
    if (!pkt_ready) nready_cnt++;
    if (pkt_valid && pkt_ready) acc_cnt++;
    if (done) begin
      done_cnt++;
      done_gap = cyc - hs_cyc;
    end
    if (prev_stall && tx_valid) begin
      n_checks++;
      if (tx_data !== prev_data) begin
        n_fail++;
        $display("FAIL stall_stable: tx_data %h, held value %h", tx_data, prev_data);
      end
    end
    if (tx_valid && tx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %h, expected no byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, e);
        end
      end
      hs_cyc = cyc;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic next_ready();
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic accept(input logic [7:0] op, input logic [7:0] len, input logic [8*MAXP-1:0] pay);
    int n;
    @(posedge CLK); #1;
    pkt_opcode = op; pkt_len = len; pkt_payload = pay; pkt_valid = 1'b1;
    next_ready();
    tick();
    n = 0;
    while (!pkt_ready && n < 50) begin
      @(posedge CLK); #1; next_ready(); tick(); n++;
    end
    n_checks++;
    if (!pkt_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: pkt_ready %b, required 1", pkt_ready);
    end
    @(posedge CLK); #1;
    pkt_valid = 1'b0;
    pkt_opcode = 8'($urandom); pkt_len = 8'($urandom);
    pkt_payload = {4{$urandom}};
    next_ready();
    tick();
  endtask

  task automatic wait_drain(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge CLK); #1; next_ready(); tick();
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    repeat (2) begin @(posedge CLK); #1; tick(); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_checks += 6;
    if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    if (err_len !== 1'b0)   begin n_fail++; $display("FAIL rst_err_len: got %b expected 0", err_len); end
    if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_ready: got %b expected 0", pkt_ready); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (pkt_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", pkt_ready); end
  endtask

  task automatic test_basic();
    int b0, d0;
    bit ok;
    tx_ready = 1'b1; rand_ready = 0;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h02); exp_q.push_back(8'h07);
    exp_q.push_back(8'h20); exp_q.push_back(8'h5D);
    b0 = busy_cnt; d0 = done_cnt;
    accept(8'h07, 8'd1, {{(8*MAXP-8){1'b0}}, 8'h20});
    wait_drain(40, ok);
    n_checks += 4;
    if (!ok)                 begin n_fail++; $display("FAIL basic_drain: left %0d bytes, expected 0", exp_q.size()); end
    if (busy_cnt - b0 != 5)  begin n_fail++; $display("FAIL basic_busy: %0d cycles, expected 5", busy_cnt - b0); end
    if (done_cnt - d0 != 1)  begin n_fail++; $display("FAIL basic_done: %0d pulses, expected 1", done_cnt - d0); end
    if (done_gap != 1)       begin n_fail++; $display("FAIL basic_done_timing: gap %0d, expected 1", done_gap); end
  endtask

  task automatic test_zero_len();
    int b0, d0;
    bit ok;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h12);
    b0 = busy_cnt; d0 = done_cnt;
    accept(8'h01, 8'd0, '0);
    wait_drain(40, ok);
    n_checks += 3;
    if (!ok)                begin n_fail++; $display("FAIL zero_drain: left %0d bytes, expected 0", exp_q.size()); end
    if (busy_cnt - b0 != 4) begin n_fail++; $display("FAIL zero_busy: %0d cycles, expected 4", busy_cnt - b0); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done: %0d pulses, expected 1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int d0;
    bit ok;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h02); exp_q.push_back(8'h07);
    exp_q.push_back(8'h20); exp_q.push_back(8'h5D);
    d0 = done_cnt; rand_ready = 1;
    accept(8'h07, 8'd1, {{(8*MAXP-8){1'b0}}, 8'h20});
    wait_drain(400, ok);
    rand_ready = 0; tx_ready = 1'b1;
    n_checks += 2;
    if (!ok)                begin n_fail++; $display("FAIL stall_drain: left %0d bytes, expected 0", exp_q.size()); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_done: %0d pulses, expected 1", done_cnt - d0); end
  endtask

  task automatic test_len_err();
    int e0, t0, r0, b0;
    e0 = err_cnt; t0 = txv_cnt; r0 = nready_cnt; b0 = busy_cnt;
    @(posedge CLK); #1;
    pkt_opcode = 8'h55; pkt_len = 8'(MAXP + 1); pkt_valid = 1'b1;
    tick();
    @(posedge CLK); #1;
    pkt_valid = 1'b0;
    tick();
    repeat (8) begin @(posedge CLK); #1; tick(); end
    n_checks += 4;
    if (err_cnt - e0 != 1)    begin n_fail++; $display("FAIL lenerr_pulse: %0d pulses, expected 1", err_cnt - e0); end
    if (txv_cnt - t0 != 0)    begin n_fail++; $display("FAIL lenerr_tx_valid: %0d cycles, expected 0", txv_cnt - t0); end
    if (nready_cnt - r0 != 0) begin n_fail++; $display("FAIL lenerr_ready: %0d low cycles, expected 0", nready_cnt - r0); end
    if (busy_cnt - b0 != 0)   begin n_fail++; $display("FAIL lenerr_busy: %0d cycles, expected 0", busy_cnt - b0); end
  endtask

  task automatic test_back_to_back();
    logic [8*MAXP-1:0] pa, pb;
    int d0, done1, sync2;
    bit switched, fin;
    pa = {4{$urandom}}; pb = {4{$urandom}};
    push_frame(8'h33, 8'd3, pa);
    push_frame(8'hC4, 8'd16, pb);
    d0 = done_cnt; acc_cnt = 0; done1 = -1; sync2 = -1; switched = 0; fin = 0;
    @(posedge CLK); #1;
    pkt_opcode = 8'h33; pkt_len = 8'd3; pkt_payload = pa; pkt_valid = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) begin
      @(posedge CLK); #1;
      if (acc_cnt == 1 && !switched) begin
        pkt_opcode = 8'hC4; pkt_len = 8'd16; pkt_payload = pb; switched = 1;
      end
      if (acc_cnt >= 2) pkt_valid = 1'b0;
      tick();
      if (done && done1 < 0) done1 = cyc;
      if (done1 >= 0 && sync2 < 0 && cyc > done1 && tx_valid && tx_data == 8'hAA) sync2 = cyc;
      if (acc_cnt >= 2 && exp_q.size() == 0 && !busy) begin fin = 1; break; end
    end
    pkt_valid = 1'b0;
    n_checks += 3;
    if (!fin)                begin n_fail++; $display("FAIL b2b_drain: left %0d bytes, expected 0", exp_q.size()); end
    if (done_cnt - d0 != 2)  begin n_fail++; $display("FAIL b2b_done: %0d pulses, expected 2", done_cnt - d0); end
    if (sync2 < 0 || sync2 - done1 > 2)
      begin n_fail++; $display("FAIL b2b_gap: sync2 %0d done1 %0d, expected gap 1..2", sync2, done1); end
  endtask

  task automatic test_reset_mid();
    logic [8*MAXP-1:0] p;
    int d0, n;
    bit ok;
    p = {4{$urandom}};
    push_frame(8'h9A, 8'd16, p);
    d0 = done_cnt;
    accept(8'h9A, 8'd16, p);
    n = 0;
    while (exp_q.size() > 14 && n < 30) begin @(posedge CLK); #1; tick(); n++; end
    @(posedge CLK); #2;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", pkt_ready); end
    if (n >= 30)            begin n_fail++; $display("FAIL midrst_reach: %0d bytes left, expected 14", exp_q.size()); end
    exp_q.delete();
    repeat (2) tick();
    @(posedge CLK); #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL midrst_done: %0d pulses, expected 0", done_cnt - d0); end
    p = {4{$urandom}};
    push_frame(8'h5C, 8'd5, p);
    d0 = done_cnt;
    accept(8'h5C, 8'd5, p);
    wait_drain(60, ok);
    n_checks += 2;
    if (!ok)                begin n_fail++; $display("FAIL postrst_drain: left %0d bytes, expected 0", exp_q.size()); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL postrst_done: %0d pulses, expected 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
